// File: rtl/ifetch_seq_ctrl.sv
// Purpose: instruction fetch sequencer; owns the PC, requests words from imem, hands them to decode.
// Latency: one cycle from imem_ack to instr_valid; peak throughput one instruction every two cycles.
// Backpressure: holds instr/instr_pc while instr_ready=0; a redirect drops them; halt waits for a handshake.
// Optional build: define IFETCH_PERF_CNT_EN to add the fetch_cnt/stall_cnt performance counters.
module ifetch_seq_ctrl #(
    parameter int unsigned AWIDTH   = 6,
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    output logic [DWIDTH-1:0] instr,
    output logic [AWIDTH-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [AWIDTH-1:0] redirect_addr,
    input  logic              halt,
    output logic              halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        VALID = 3'd2,
        FLUSH = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [AWIDTH-1:0] RESET_PC_W = AWIDTH'(RESET_PC);
    localparam logic [AWIDTH-1:0] PC_STEP    = AWIDTH'(1);

    state_t            state;
    logic [AWIDTH-1:0] pc;

    // Sequencer FSM; every output is a register so decode and imem see clean timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC_W;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (halt) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                end
                FETCH: begin
                    if (redirect_valid && imem_ack) begin
                        // Returned word is on the wrong path: drop it and reissue at the target.
                        imem_addr <= redirect_addr;
                        pc        <= redirect_addr;
                    end else if (redirect_valid) begin
                        // The in-flight request must still complete before a new one may start.
                        pc    <= redirect_addr;
                        state <= FLUSH;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= imem_addr;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        pc          <= imem_addr + PC_STEP;
                        state       <= VALID;
                    end
                end
                FLUSH: begin
                    // Only the newest redirect target matters, so a late redirect wins over pc.
                    if (redirect_valid) begin
                        pc <= redirect_addr;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect_valid ? redirect_addr : pc;
                        state     <= FETCH;
                    end
                end
                VALID: begin
                    if (redirect_valid) begin
                        // Redirect squashes the held instruction and outranks halt.
                        pc          <= redirect_addr;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= redirect_addr;
                        state       <= FETCH;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                            state     <= FETCH;
                        end
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        pc        <= redirect_addr;
                        halted    <= 1'b0;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_addr;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Count decode handshakes and cycles where decode holds off a valid instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (instr_valid && instr_ready) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end
            if (state == VALID && !instr_ready) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
